// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encodings and default width for the serial add/sub
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } addsub_state_t;

endpackage

// File: rtl/full_adder_nand.sv
// rtl/full_adder_nand.sv - one-bit full adder built only from two-input NAND gates
module full_adder_nand (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic n1, n2, n3, x1, n5, n6, n7;

    // Classic nine-gate form: first half adder yields a^b, second folds in cin
    assign n1   = ~(a & b);
    assign n2   = ~(a & n1);
    assign n3   = ~(b & n1);
    assign x1   = ~(n2 & n3);
    assign n5   = ~(x1 & cin);
    assign n6   = ~(x1 & n5);
    assign n7   = ~(cin & n5);
    assign sum  = ~(n6 & n7);
    assign cout = ~(n5 & n1);

endmodule

// File: rtl/serial_addsub_nand.sv
// rtl/serial_addsub_nand.sv - bit-serial add/subtract, LSB first through one NAND full adder
module serial_addsub_nand
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

    addsub_state_t state, state_next;
    logic          accept;

    logic [WIDTH-1:0] sa, sb;
    logic             carry;
    logic             carry_msb;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;

    full_adder_nand u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                accept     = start;
                state_next = start ? ST_RUN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b on load and seed the carry loop with 1
    always_ff @(posedge clk) begin
        if (rst) begin
            sa        <= '0;
            sb        <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            sa        <= a;
            sb        <= sub ? ~b : b;
            carry     <= sub;
            carry_msb <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == ST_RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            result <= {fa_sum, result[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            if (cnt == CNT_MSB_IN) begin
                carry_msb <= fa_cout;
            end
            if (cnt == CNT_LAST) begin
                cout     <= fa_cout;
                overflow <= fa_cout ^ carry_msb;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_addsub_nand.sv
// tb/tb_serial_addsub_nand.sv - vector table, random ops against an arithmetic model, corner sequences
module tb_serial_addsub_nand;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;

    serial_addsub_nand #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] eres;
        logic         ecout;
        logic         eovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic and signed-range overflow rule
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0]   t;
        logic         ov;
        int           sx, sy, sr;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        sr = s ? sx - sy : sx + sy;
        ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        if (s) t = {1'b0, x} + {1'b0, ~y} + (W + 1)'(1);
        else   t = {1'b0, x} + {1'b0, y};
        return {ov, t[W], t[W-1:0]};
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen; lat = -1 on timeout
    task automatic wait_done(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
        end
        if (!got) lat = -1;
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic s, input logic [W-1:0] er, input logic ec, input logic eo);
        int lat;
        launch(x, y, s);
        wait_done(lat);
        chk({tag, " latency"}, lat, W);
        chk({tag, " result"}, result, er);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " overflow"}, overflow, eo);
        @(negedge clk);
        chk({tag, " done one cycle"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        logic [W+1:0] m;
        logic [W-1:0] ra, rb;
        logic         rs;
        bit           saw_done;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h50, 8'h60, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 8'h00);
        chk("reset cout", cout, 1'b0);
        chk("reset overflow", overflow, 1'b0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
                      vecs[i].eres, vecs[i].ecout, vecs[i].eovf);
        end

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            m  = model(ra, rb, rs);
            run_check($sformatf("rand%0d", i), ra, rb, rs, m[W-1:0], m[W], m[W+1]);
        end

        // start pulsed mid-run with different operands must be ignored
        launch(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
        wait_done(lat);
        chk("midrun latency", lat, W - 4);
        chk("midrun result", result, 8'h46);
        chk("midrun cout", cout, 1'b0);
        @(negedge clk);
        chk("midrun back idle", busy, 1'b0);

        // start held through DONE chains a second op immediately
        launch(8'h10, 8'h20, 1'b0);
        a = 8'h05; b = 8'h03; sub = 1'b1; start = 1'b1;
        wait_done(lat);
        chk("chain first latency", lat, W);
        chk("chain first result", result, 8'h30);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("chain busy resumes", busy, 1'b1);
        chk("chain result cleared", result, 8'h00);
        wait_done(lat);
        chk("chain second latency", lat, W);
        chk("chain second result", result, 8'h02);
        chk("chain second cout", cout, 1'b1);
        @(negedge clk);

        // reset while bit 3 is about to be processed aborts the op
        launch(8'hF0, 8'h0F, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy", busy, 1'b0);
        chk("abort result", result, 8'h00);
        chk("abort done", done, 1'b0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", saw_done, 1'b0);
        run_check("post abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
